// File: rtl/seq_divider_pkg.sv
// Shared constants for the RV64M sequential divider: FSM encoding and
// the RISC-V special-case result values.
package seq_divider_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CALC  = 2'd1;
  localparam logic [1:0] FIXUP = 2'd2;

  localparam logic [63:0] RV_DIV_ZERO_Q = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] RV_MIN_SIGNED = 64'h8000_0000_0000_0000;

endpackage

// File: rtl/opposite.sv
// Two's-complement negation with wrap-around at WIDTH bits.
module opposite #(
  parameter int unsigned WIDTH = 64
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] y
);

  assign y = ~a + WIDTH'(1);

endmodule

// File: rtl/seq_divider_div_step.sv
// One restoring-division iteration on the {rem, quo} register pair.
module seq_divider_div_step #(
  parameter int unsigned WORDSIZE = 64
) (
  input  logic [WORDSIZE-1:0] rem,
  input  logic [WORDSIZE-1:0] quo,
  input  logic [WORDSIZE-1:0] dvs,
  output logic [WORDSIZE-1:0] rem_nxt,
  output logic [WORDSIZE-1:0] quo_nxt
);

  logic [WORDSIZE:0] shifted;
  logic [WORDSIZE:0] diff;

  // Shifted partial remainder can need WORDSIZE+1 bits before the subtract.
  assign shifted = {rem, quo[WORDSIZE-1]};
  assign diff    = shifted - {1'b0, dvs};

  always_comb begin
    if (!diff[WORDSIZE]) begin
      rem_nxt = diff[WORDSIZE-1:0];
      quo_nxt = {quo[WORDSIZE-2:0], 1'b1};
    end else begin
      rem_nxt = shifted[WORDSIZE-1:0];
      quo_nxt = {quo[WORDSIZE-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider for RV64M DIV/DIVU/REM/REMU; signed mode divides
// magnitudes and re-applies signs in a final fixup cycle.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int unsigned WORDSIZE = 64,
  parameter int unsigned CNTW     = 7
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                is_signed,
  input  logic [WORDSIZE-1:0] dividend,
  input  logic [WORDSIZE-1:0] divisor,
  output logic                busy,
  output logic                done,
  output logic [WORDSIZE-1:0] quotient,
  output logic [WORDSIZE-1:0] remainder,
  output logic                div_by_zero
);

  localparam logic [WORDSIZE-1:0] DivZeroQ  = RV_DIV_ZERO_Q[WORDSIZE-1:0];
  localparam logic [WORDSIZE-1:0] MinSigned = RV_MIN_SIGNED[63 -: WORDSIZE];

  logic [1:0]          state_q, state_d;
  logic                sgn_q, q_neg_q, r_neg_q;
  logic [WORDSIZE-1:0] rem_q, quo_q, dvs_q;
  logic [CNTW-1:0]     cnt_q;
  logic [WORDSIZE-1:0] quotient_q, remainder_q;
  logic                dbz_q, done_q;

  logic [WORDSIZE-1:0] dividend_neg, divisor_neg, quo_neg, rem_neg;
  logic [WORDSIZE-1:0] rem_nxt, quo_nxt;
  logic                dvd_neg_in, dvs_neg_in, div_zero, overflow, calc_last;

  opposite #(.WIDTH(WORDSIZE)) u_neg_dividend (.a(dividend), .y(dividend_neg));
  opposite #(.WIDTH(WORDSIZE)) u_neg_divisor  (.a(divisor),  .y(divisor_neg));
  opposite #(.WIDTH(WORDSIZE)) u_neg_quo      (.a(quo_q),    .y(quo_neg));
  opposite #(.WIDTH(WORDSIZE)) u_neg_rem      (.a(rem_q),    .y(rem_neg));

  seq_divider_div_step #(.WORDSIZE(WORDSIZE)) u_step (
    .rem    (rem_q),
    .quo    (quo_q),
    .dvs    (dvs_q),
    .rem_nxt(rem_nxt),
    .quo_nxt(quo_nxt)
  );

  assign dvd_neg_in = is_signed & dividend[WORDSIZE-1];
  assign dvs_neg_in = is_signed & divisor[WORDSIZE-1];
  assign div_zero   = (divisor == '0);
  assign overflow   = is_signed && (dividend == MinSigned) && (divisor == DivZeroQ);
  assign calc_last  = (cnt_q == CNTW'(WORDSIZE - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start && !div_zero && !overflow) state_d = CALC;
      CALC:    if (calc_last) state_d = FIXUP;
      FIXUP:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state_q != IDLE);
    done        = done_q;
    quotient    = quotient_q;
    remainder   = remainder_q;
    div_by_zero = dbz_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sgn_q       <= 1'b0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (div_zero) begin
              quotient_q  <= DivZeroQ;
              remainder_q <= dividend;
              dbz_q       <= 1'b1;
              done_q      <= 1'b1;
            end else if (overflow) begin
              quotient_q  <= dividend;
              remainder_q <= '0;
              dbz_q       <= 1'b0;
              done_q      <= 1'b1;
            end else begin
              sgn_q   <= is_signed;
              q_neg_q <= dvd_neg_in ^ dvs_neg_in;
              r_neg_q <= dvd_neg_in;
              rem_q   <= '0;
              quo_q   <= dvd_neg_in ? dividend_neg : dividend;
              dvs_q   <= dvs_neg_in ? divisor_neg : divisor;
              cnt_q   <= '0;
            end
          end
        end
        CALC: begin
          rem_q <= rem_nxt;
          quo_q <= quo_nxt;
          cnt_q <= cnt_q + CNTW'(1);
        end
        FIXUP: begin
          quotient_q  <= (sgn_q && q_neg_q) ? quo_neg : quo_q;
          remainder_q <= (sgn_q && r_neg_q) ? rem_neg : rem_q;
          dbz_q       <= 1'b0;
          done_q      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
